// File: rtl/fetch_unit.sv
// fetch_unit: PC register and req/rdy instruction fetch feeding the control unit.
// Optional misaligned-target trap (misaligned output, HALT state) when FETCH_MISALIGN_TRAP_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemRdy,
    input  logic [31:0] imemData,
    input  logic        instrAccept,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [6:0]  op,
    output logic [2:0]  f3,
    output logic        f7,
    output logic [31:0] pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic [31:0] pcPlus4
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        , HALT
`endif
    } state_t;

    state_t      state;
    logic [31:0] next_pc;

    assign imemAddr = pc;
    assign pcPlus4  = pc + 32'd4;
    assign op       = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[30];
    assign next_pc  = pcSrc ? (pcTarget & 32'hFFFF_FFFC) : pcPlus4;

    // Fetch FSM: request, capture the returned word, hold it until the core accepts, then advance pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imemReq    <= 1'b0;
            instrValid <= 1'b0;
            instr      <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state   <= REQ;
                    imemReq <= 1'b1;
                end
                REQ: if (imemRdy) begin
                    instr      <= imemData;
                    instrValid <= 1'b1;
                    imemReq    <= 1'b0;
                    state      <= HOLD;
                end
                HOLD: if (instrAccept) begin
                    instrValid <= 1'b0;
                    instr      <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (pcSrc && pcTarget[1:0] != 2'b00) begin
                        misaligned <= 1'b1;
                        pc         <= pcTarget;
                        state      <= HALT;
                    end else begin
                        pc      <= next_pc;
                        imemReq <= 1'b1;
                        state   <= REQ;
                    end
`else
                    pc      <= next_pc;
                    imemReq <= 1'b1;
                    state   <= REQ;
`endif
                end
                default: state <= IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
                HALT: state <= HALT;
`endif
            endcase
        end
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and fetches from a variable-latency instruction memory through a req/rdy handshake.
- Presents the instruction (and the op/f3/f7 fields the control unit decodes) until the core accepts it.
- Takes the control unit's pcSrc plus the datapath branch/jump target to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imemReq  out  1  fetch request to instruction memory.
- imemAddr  out  32  fetch address, equal to pc, stable while imemReq=1.
- imemRdy  in  1  memory returns data this cycle; honoured only while imemReq=1.
- imemData  in  32  instruction word, sampled when imemReq&imemRdy.
- instrAccept  in  1  core consumes the held instruction this cycle.
- pcSrc  in  1  take pcTarget; from control unit, sampled only on accept.
- pcTarget  in  32  branch/jump target from datapath.
- instr  out  32  held instruction word.
- instrValid  out  1  instr is valid.
- op  out  7  instr[6:0].
- f3  out  3  instr[14:12].
- f7  out  1  instr[30].
- pc  out  32  address of held/requested instruction.
- pcPlus4  out  32  pc+4 for jal/jalr writeback.

Behaviour:
- Reset (async, immediate, asserted or mid-operation):
  - state=IDLE, pc=RESET_PC, imemReq=0, instrValid=0, instr=NOP_INSTR.
  - Any in-flight memory response is discarded.
- States: IDLE, REQ, HOLD (plus HALT with the optional feature).
- IDLE: imemReq=0. Goes to REQ on the first clock edge after rst deasserts.
- REQ:
  - imemReq=1, imemAddr=pc.
  - On imemReq&imemRdy: instr<=imemData, instrValid<=1, go to HOLD.
  - Otherwise stay; pc and imemAddr are held.
  - Zero-wait memory (imemRdy high the same cycle as req) is legal.
- HOLD:
  - imemReq=0, instrValid=1, instr stable.
  - On instrAccept: pc<=pcSrc ? {pcTarget[31:2],2'b00} : pc+4; instrValid<=0; instr<=NOP_INSTR; go to REQ.
  - Without instrAccept: stay; pcSrc and pcTarget are ignored.
- Ignored inputs:
  - instrAccept outside HOLD.
  - imemRdy outside REQ.
  - pcSrc whenever not accepting.
- Throughput: minimum 2 cycles per instruction (REQ with same-cycle rdy, then HOLD with accept).
- Arithmetic: pc+4 and pcPlus4 are modulo 2^32; 32'hFFFF_FFFC wraps to 0. pcPlus4 is combinational from pc.
- op/f3/f7 are combinational slices of instr. While invalid they decode NOP_INSTR (op=7'h13).
- Simultaneous events: accept with pcSrc=1 takes the redirect. Target bits [1:0] are forced to 0 without the optional feature.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit, reset 0) and state HALT.
  - On accept with pcSrc=1 and pcTarget[1:0]!=0: misaligned<=1, pc<=pcTarget unmodified, go to HALT.
  - HALT: imemReq=0, instrValid=0; only rst leaves it.
- Undefined:
  - No misaligned port, no HALT state.
  - Target low bits are silently cleared.

Test Plan:
- Reset then zero-wait memory, instrAccept=1, pcSrc=0 -> imemAddr sequence 0,4,8,C; one instruction every 2 cycles; pcPlus4=pc+4.
- Memory with 3 wait cycles -> imemReq and imemAddr=0 held 4 cycles; instrValid rises the cycle after imemRdy; instr=imemData.
- HOLD with instrAccept=0 for 5 cycles while pcSrc toggles -> instr, pc and instrValid unchanged, imemReq=0; then accept with pcSrc=1, pcTarget=0x40 -> next imemAddr=0x40.
- Instruction 0x00A58463 (beq) held -> op=7'h63, f3=3'b000, f7=0. Accept with pcSrc=0 at pc=0xFFFFFFFC -> next pc=0x0.
- rst asserted mid-REQ with imemRdy pulsing -> imemReq=0 immediately, pc=RESET_PC, instrValid=0, instr=0x13; fetch restarts at RESET_PC.
- FETCH_MISALIGN_TRAP_EN defined: accept with pcSrc=1, pcTarget=0x102 -> misaligned=1, HALT, imemReq stays 0. Undefined: same stimulus -> next imemAddr=0x100.
